div: RTL and testbench
======================

// Module: div
// PURPOSE
//  Serial restoring divider; the inverse of the serial multiplier. Used by the
//  EX stage for DIV/DIVU.
//  - Same go/hold stall handshake as the multiplier; one quotient bit per clock.
//  - res = {remainder, quotient}, i.e. HI:LO order.
// PARAMETERS
//  WIDTH  32  operand width; res is 2*WIDTH; iteration counter is clog2(WIDTH)+1 bits
// PORTS
//  clk      in   1        clock, all state on posedge
//  rst      in   1        asynchronous, active-low reset
//  op1      in   WIDTH    dividend, sampled only on the start cycle
//  op2      in   WIDTH    divisor, sampled only on the start cycle
//  signed_  in   1        1 = DIV (two's complement), 0 = DIVU; sampled at start
//  go       in   1        request; held high by the consumer until it sees hold low
//  res      out  2*WIDTH  {rem[WIDTH-1:0], quo[WIDTH-1:0]}; valid while valid=1
//  hold     out  1        go & ~valid; the consumer stalls while this is high
// BEHAVIOUR
//  Reset (rst low, async):
//   - state=IDLE, ready=1, valid=0, res=0, counter=0.
//   - Any operation in flight is dropped; hold=go while rst is low.
//  FSM states: IDLE, BUSY, FIX, DONE.
//   IDLE
//    - valid=0.
//    - Start condition: go & ready. On start, latch |op1| and |op2|.
//      Magnitude is the two's-complement negation when signed_ and the MSB is set.
//    - Also latch sign_q = signed_&(op1^op2)[MSB] and sign_r = signed_&op1[MSB].
//    - Clear the partial remainder, load counter=WIDTH, go to BUSY.
//    - Exception: if op2==0, skip BUSY/FIX and go straight to DONE with
//      quo = all ones, rem = op1 (raw, unsigned view).
//   BUSY: one step per clock, WIDTH clocks.
//    - r' = {r[WIDTH-1:0], d[MSB]}; d <<= 1.
//    - If r' >= divisor: r = r' - divisor and shift in 1; else r = r' and shift in 0.
//    - r is WIDTH+1 bits wide so it cannot overflow.
//    - Counter decrements; at 1 -> FIX.
//   FIX: one clock.
//    - quo = sign_q ? -q : q; rem = sign_r ? -r : r.
//    - Write res, go to DONE.
//   DONE: one clock.
//    - valid=1, so hold=0 for exactly this cycle.
//    - ready=0 here, so no new start this cycle. Go to IDLE.
//  Latency:
//   - go high in IDLE at cycle 0 -> hold low in cycle WIDTH+2 (34).
//   - Divide by zero: hold low in cycle 1.
//   - With go held high, the next op starts in the IDLE cycle after DONE.
//     Steady state: one result every WIDTH+3 cycles.
//  Corner rules:
//   - The hold low pulse never lasts 2 consecutive cycles.
//   - If go drops mid-operation, the operation completes; res updates and valid pulses.
//   - op1/op2/signed_ changes after the start cycle are ignored.
//   - -2^31 / -1 (signed) gives quo=0x80000000, rem=0 (natural wrap, no trap).
//   - res holds its value outside DONE until the next FIX or divide-by-zero start.
// TESTING
//  1. DIVU 100/7, go held -> hold low only in cycle 34; res = {32'd2, 32'd14}.
//  2. DIV -7/2 -> quo=32'hFFFFFFFD, rem=32'hFFFFFFFF. DIV 7/-2 -> quo=32'hFFFFFFFD, rem=1.
//  3. DIVU 0xDEADBEEF/0 -> hold low in cycle 1; res = {32'hDEADBEEF, 32'hFFFFFFFF}.
//  4. DIV 0x80000000/0xFFFFFFFF -> res = {32'h0, 32'h80000000}. DIVU same operands -> {32'h80000000, 32'h0}.
//  5. Back-to-back, go never dropped, 10/3 then 9/3 -> hold low at cycles 34 and 69 only;
//     results {1,3} and {0,3}; a check asserts no two consecutive hold-low cycles.
//  6. Assert rst low at BUSY cycle 12, release, keep go high -> res=0 during reset;
//     a fresh op restarts and completes 34 cycles after release.

Source files
------------

// File: rtl/div_if.sv
// div_if: operand/result handshake bundle between the EX stage and the serial divider
//   op1/op2/signed_/go : consumer -> divider, sampled on the start cycle
//   res/hold/valid     : divider -> consumer, res = {rem, quo}
interface div_if #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic signed_;
  logic go;
  logic [2*WIDTH-1:0] res;
  logic hold;
  logic valid;
  modport master(output op1, op2, signed_, go, input res, hold, valid);
  modport slave(input op1, op2, signed_, go, output res, hold, valid);
endinterface

// File: rtl/div.sv
// div: serial restoring divider, one quotient bit per clock, res = {rem, quo}
//   clk : clock, all state on posedge
//   rst : asynchronous active-low reset
//   bus : div_if slave (op1, op2, signed_, go in; res, hold, valid out)
module div #(parameter int WIDTH = 32) (
  input logic clk,
  input logic rst,
  div_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] d, dv, r, a_mag, b_mag, quo, rem;
  logic [WIDTH:0] rs, diff;
  logic sign_q, sign_r, ready, start, zero, ge;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state == IDLE ? (start ? (zero ? DONE : BUSY) : IDLE) :
               state == BUSY ? (cnt == CW'(1) ? FIX : BUSY) :
               state == FIX  ? DONE : IDLE;
  end
  always_comb begin
    bus.valid = state == DONE;
    ready = state != DONE;
    start = state == IDLE && bus.go && ready;
    bus.hold = bus.go & ~bus.valid;
  end
  always_comb begin
    zero = bus.op2 == '0;
    a_mag = bus.signed_ && bus.op1[WIDTH-1] ? -bus.op1 : bus.op1;
    b_mag = bus.signed_ && bus.op2[WIDTH-1] ? -bus.op2 : bus.op2;
    rs = {r, d[WIDTH-1]};
    // rs < 2*dv, so the sign of the WIDTH+1 bit difference is the compare result
    diff = rs - {1'b0, dv};
    ge = ~diff[WIDTH];
    quo = sign_q ? -d : d;
    rem = sign_r ? -r : r;
  end
  // d doubles as the quotient: dividend bits shift out the top, quotient bits shift in below
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      d <= '0;
      dv <= '0;
      r <= '0;
      cnt <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      bus.res <= '0;
    end else if (start) begin
      d <= a_mag;
      dv <= b_mag;
      r <= '0;
      cnt <= CW'(WIDTH);
      sign_q <= bus.signed_ & (bus.op1[WIDTH-1] ^ bus.op2[WIDTH-1]);
      sign_r <= bus.signed_ & bus.op1[WIDTH-1];
      if (zero) bus.res <= {bus.op1, {WIDTH{1'b1}}};
    end else if (state == BUSY) begin
      d <= {d[WIDTH-2:0], ge};
      r <= ge ? diff[WIDTH-1:0] : rs[WIDTH-1:0];
      cnt <= cnt - 1'b1;
    end else if (state == FIX) begin
      bus.res <= {rem, quo};
    end
endmodule

// File: tb/tb_div.sv
// tb_div: directed self-checking bench for the serial divider
module tb_div;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  div_if #(.WIDTH(32)) bus();
  div #(.WIDTH(32)) dut(.clk(clk), .rst(rst), .bus(bus));

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        output int lat, output logic [63:0] r, output logic h_after);
    @(posedge clk); #1;
    bus.op1 = a; bus.op2 = b; bus.signed_ = s; bus.go = 1'b1;
    lat = -1; r = '0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (c == 3) begin bus.op1 = ~a; bus.op2 = b + 1; bus.signed_ = ~s; end
      if (!bus.hold) begin lat = c; r = bus.res; break; end
    end
    @(negedge clk);
    h_after = bus.hold;
    bus.go = 1'b0;
  endtask

  task automatic test_reset;
    bus.go = 1'b0; bus.op1 = '0; bus.op2 = '0; bus.signed_ = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (bus.res !== 64'h0) begin bad++; $display("FAIL reset_res got=%h want=%h", bus.res, 64'h0); end
    total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.valid); end
    total++; if (bus.hold !== 1'b0) begin bad++; $display("FAIL reset_hold_go0 got=%b want=0", bus.hold); end
    bus.go = 1'b1; #1;
    total++; if (bus.hold !== 1'b1) begin bad++; $display("FAIL reset_hold_go1 got=%b want=1", bus.hold); end
    bus.go = 1'b0;
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_divu;
    int lat; logic [63:0] r; logic h;
    run_op(32'd100, 32'd7, 1'b0, lat, r, h);
    total++; if (lat !== 34) begin bad++; $display("FAIL divu_lat got=%0d want=34", lat); end
    total++; if (r !== 64'h00000002_0000000E) begin bad++; $display("FAIL divu_res got=%h want=%h", r, 64'h00000002_0000000E); end
    total++; if (h !== 1'b1) begin bad++; $display("FAIL divu_hold_after got=%b want=1", h); end
  endtask

  task automatic test_signed;
    int lat; logic [63:0] r; logic h;
    run_op(-32'sd7, 32'd2, 1'b1, lat, r, h);
    total++; if (r !== 64'hFFFFFFFF_FFFFFFFD) begin bad++; $display("FAIL div_m7_2 got=%h want=%h", r, 64'hFFFFFFFF_FFFFFFFD); end
    total++; if (lat !== 34) begin bad++; $display("FAIL div_m7_2_lat got=%0d want=34", lat); end
    run_op(32'd7, -32'sd2, 1'b1, lat, r, h);
    total++; if (r !== 64'h00000001_FFFFFFFD) begin bad++; $display("FAIL div_7_m2 got=%h want=%h", r, 64'h00000001_FFFFFFFD); end
  endtask

  task automatic test_div_zero;
    int lat; logic [63:0] r; logic h;
    run_op(32'hDEADBEEF, 32'h0, 1'b0, lat, r, h);
    total++; if (lat !== 1) begin bad++; $display("FAIL dz_lat got=%0d want=1", lat); end
    total++; if (r !== 64'hDEADBEEF_FFFFFFFF) begin bad++; $display("FAIL dz_res got=%h want=%h", r, 64'hDEADBEEF_FFFFFFFF); end
    total++; if (h !== 1'b1) begin bad++; $display("FAIL dz_hold_after got=%b want=1", h); end
  endtask

  task automatic test_overflow;
    int lat; logic [63:0] r; logic h;
    run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, lat, r, h);
    total++; if (r !== 64'h00000000_80000000) begin bad++; $display("FAIL ovf_signed got=%h want=%h", r, 64'h00000000_80000000); end
    run_op(32'h80000000, 32'hFFFFFFFF, 1'b0, lat, r, h);
    total++; if (r !== 64'h80000000_00000000) begin bad++; $display("FAIL ovf_unsigned got=%h want=%h", r, 64'h80000000_00000000); end
  endtask

  task automatic test_back_to_back;
    int low1 = -1, low2 = -1, lows = 0, consec = 0;
    logic prev = 1'b1;
    logic [63:0] r1 = '0, r2 = '0;
    @(posedge clk); #1;
    bus.op1 = 32'd10; bus.op2 = 32'd3; bus.signed_ = 1'b0; bus.go = 1'b1;
    for (int c = 0; c <= 70; c++) begin
      @(negedge clk);
      if (!bus.hold) begin
        lows++;
        if (!prev) consec++;
        if (low1 < 0) begin low1 = c; r1 = bus.res; bus.op1 = 32'd9; end
        else if (low2 < 0) begin low2 = c; r2 = bus.res; end
      end
      prev = bus.hold;
    end
    bus.go = 1'b0;
    total++; if (low1 !== 34) begin bad++; $display("FAIL b2b_low1 got=%0d want=34", low1); end
    total++; if (low2 !== 69) begin bad++; $display("FAIL b2b_low2 got=%0d want=69", low2); end
    total++; if (lows !== 2) begin bad++; $display("FAIL b2b_lows got=%0d want=2", lows); end
    total++; if (consec !== 0) begin bad++; $display("FAIL b2b_consec got=%0d want=0", consec); end
    total++; if (r1 !== 64'h00000001_00000003) begin bad++; $display("FAIL b2b_res1 got=%h want=%h", r1, 64'h00000001_00000003); end
    total++; if (r2 !== 64'h00000000_00000003) begin bad++; $display("FAIL b2b_res2 got=%h want=%h", r2, 64'h00000000_00000003); end
  endtask

  task automatic test_go_drop;
    int vfirst = -1, vcnt = 0;
    logic [63:0] r = '0;
    @(posedge clk); #1;
    bus.op1 = 32'd21; bus.op2 = 32'd4; bus.signed_ = 1'b0; bus.go = 1'b1;
    for (int c = 0; c <= 40; c++) begin
      @(negedge clk);
      if (c == 5) bus.go = 1'b0;
      if (bus.valid) begin
        vcnt++;
        if (vfirst < 0) begin vfirst = c; r = bus.res; end
      end
    end
    total++; if (vfirst !== 34) begin bad++; $display("FAIL godrop_valid_cycle got=%0d want=34", vfirst); end
    total++; if (vcnt !== 1) begin bad++; $display("FAIL godrop_valid_count got=%0d want=1", vcnt); end
    total++; if (r !== 64'h00000001_00000005) begin bad++; $display("FAIL godrop_res got=%h want=%h", r, 64'h00000001_00000005); end
  endtask

  task automatic test_reset_mid;
    int lat = -1;
    logic [63:0] r = '0, r33 = 64'hx;
    @(posedge clk); #1;
    bus.op1 = 32'd100; bus.op2 = 32'd7; bus.signed_ = 1'b0; bus.go = 1'b1;
    repeat (13) @(negedge clk);
    rst = 1'b0; #1;
    total++; if (bus.res !== 64'h0) begin bad++; $display("FAIL rstmid_res got=%h want=%h", bus.res, 64'h0); end
    total++; if (bus.hold !== 1'b1) begin bad++; $display("FAIL rstmid_hold got=%b want=1", bus.hold); end
    bus.op1 = 32'd50; bus.op2 = 32'd5;
    @(negedge clk);
    rst = 1'b1;
    for (int c = 1; c < 100; c++) begin
      @(negedge clk);
      if (c == 33) r33 = bus.res;
      if (!bus.hold) begin lat = c; r = bus.res; break; end
    end
    @(negedge clk);
    bus.go = 1'b0;
    total++; if (r33 !== 64'h0) begin bad++; $display("FAIL rstmid_res_fix got=%h want=%h", r33, 64'h0); end
    total++; if (lat !== 34) begin bad++; $display("FAIL rstmid_lat got=%0d want=34", lat); end
    total++; if (r !== 64'h00000000_0000000A) begin bad++; $display("FAIL rstmid_newres got=%h want=%h", r, 64'h00000000_0000000A); end
  endtask

  initial begin
    test_reset;
    test_divu;
    test_signed;
    test_div_zero;
    test_overflow;
    test_back_to_back;
    test_go_drop;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end
endmodule
